// File: rtl/sync_fifo_pkg.sv
// Pointer helpers shared by the FIFO read and write control blocks.
// Pointers carry a phase bit above the address so non-power-of-two depths wrap correctly.
`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 5
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package sync_fifo_pkg;

  localparam int PKG_DEPTH = `CFG_FIFO_DEPTH;
  localparam int PTR_AW    = $clog2(PKG_DEPTH);

  typedef logic [PTR_AW:0] ptr_t;
  typedef logic [PTR_AW:0] cnt_t;

  function automatic ptr_t ptr_next(input ptr_t ptr, input cnt_t depth);
    ptr_t nxt;
    if ({1'b0, ptr[PTR_AW-1:0]} == depth - cnt_t'(1))
      nxt = {~ptr[PTR_AW], {PTR_AW{1'b0}}};
    else
      nxt = ptr + ptr_t'(1);
    return nxt;
  endfunction

  // Words between rd and wr; a phase mismatch means wr has wrapped past rd.
  function automatic cnt_t ptr_occupancy(input ptr_t wr, input ptr_t rd, input cnt_t depth);
    cnt_t wa;
    cnt_t ra;
    cnt_t occ;
    wa = {1'b0, wr[PTR_AW-1:0]};
    ra = {1'b0, rd[PTR_AW-1:0]};
    if (wr[PTR_AW] == rd[PTR_AW])
      occ = wa - ra;
    else
      occ = depth - ra + wa;
    return occ;
  endfunction

endpackage

// File: rtl/read_control_fwft_out_buf.sv
// Two-entry first-word-fall-through holding buffer: head is presented, tail queues behind it.
// Capture and pop in one cycle are both honoured; clear discards everything and wins.
module rd_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            held_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            held_q, held_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    held_d = held_q;
    if (clear_i) begin
      held_d = 2'd0;
    end else begin
      case ({capture_i, pop_i})
        2'b10: begin
          if (held_q == 2'd0) head_d = cap_data_i;
          else                tail_d = cap_data_i;
          held_d = held_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          held_d = held_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (held_q == 2'd1) begin
            head_d = cap_data_i;
          end else begin
            head_d = tail_q;
            tail_d = cap_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      held_q <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      held_q <= held_d;
    end
  end

  assign head_o  = head_q;
  assign held_o  = held_q;
  assign valid_o = (held_q != 2'd0);

endmodule

// File: rtl/read_control_fwft.sv
// FIFO read control: read pointer, status, memory issue and FWFT output; 2-cycle issue-to-valid, one word/cycle.
// Issue stalls when buffer + in-flight reach 2 without a pop. Define FIFO_RD_FLUSH_EN for the rd_flush port.
`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 5
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module read_control_fwft
  import sync_fifo_pkg::*;
#(
  parameter int MEM_DEPTH  = `CFG_FIFO_DEPTH,
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH+1:0] rd_count
`ifdef FIFO_RD_FLUSH_EN
  ,
  input  logic                  rd_flush
`endif
);

  localparam int CW = ADDR_WIDTH + 2;

  ptr_t       rd_ptr_q, rd_ptr_d;
  logic       inflight_q;
  logic [1:0] held;
  logic [1:0] ob_cnt;
  cnt_t       mem_count;
  logic       mem_empty;
  logic       pop;
  logic       flush;

`ifdef FIFO_RD_FLUSH_EN
  assign flush = rd_flush;
`else
  assign flush = 1'b0;
`endif

  assign pop       = rd_valid & rd_ready;
  assign mem_empty = (rd_ptr_q == wr_ptr);
  assign ob_cnt    = held + {1'b0, inflight_q};
  // A same-cycle pop frees a slot, so issue can continue at full rate.
  assign mem_rd_en = reset_n & ~flush & ~mem_empty & ((ob_cnt < 2'd2) | pop);

  assign mem_count       = ptr_occupancy(wr_ptr, rd_ptr_q, cnt_t'(MEM_DEPTH));
  assign rd_count        = CW'(mem_count) + CW'(ob_cnt);
  assign rd_empty        = (rd_count == '0);
  assign rd_almost_empty = (rd_count <= CW'(AE_THRESH));
  assign rd_ptr          = rd_ptr_q;
  assign mem_rd_addr     = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (flush)
      rd_ptr_d = wr_ptr;
    else if (mem_rd_en)
      rd_ptr_d = ptr_next(rd_ptr_q, cnt_t'(MEM_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= mem_rd_en;
    end
  end

  // Clear beats the capture of a word that was in flight when the flush hit.
  rd_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_i  (inflight_q),
    .cap_data_i (mem_rd_data),
    .pop_i      (pop),
    .clear_i    (flush),
    .head_o     (rd_data),
    .held_o     (held),
    .valid_o    (rd_valid)
  );

endmodule

// File: tb/tb_read_control_fwft.sv
// Bench for read_control_fwft at MEM_DEPTH=5: count-based stream model plus directed literal checks.
`timescale 1ns/1ps
module tb_read_control_fwft;

  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [AW:0]   rd_ptr;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          rd_almost_empty;
  logic [AW+1:0] rd_count;
  logic          rd_flush = 1'b0;

  always #5 clk = ~clk;

  read_control_fwft #(
    .MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .AE_THRESH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_ptr(wr_ptr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .rd_ptr(rd_ptr), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty), .rd_count(rd_count)
`ifdef FIFO_RD_FLUSH_EN
    , .rd_flush(rd_flush)
`endif
  );

  // Synchronous memory with one cycle of read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk or negedge reset_n)
    if (!reset_n)       mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Model state: words written, issued to memory, arrived in the buffer, popped.
  int            w;
  logic [DW-1:0] wq[$];
  int            n_iss, n_arr, n_pop;
  bit            prev_iss;
  int            pops, ae_rise;
  bit            ae_prev, saw_ph1;
  int            n_vec, n_err;

  function automatic logic [AW:0] ptr_of(input int n);
    return {1'((n / DEPTH) % 2), AW'(n % DEPTH)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic put(input logic [DW-1:0] d);
    mem[w % DEPTH] = d;
    wq.push_back(d);
    w++;
    wr_ptr = ptr_of(w);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    wr_ptr   = '0;
    w        = 0;
    wq.delete();
    rd_ready = 1'b0;
    rd_flush = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      n_iss = 0; n_arr = 0; n_pop = 0; prev_iss = 0; ae_prev = 1;
    end else begin : model
      bit m_valid, m_pop, m_iss, m_fl;
`ifdef FIFO_RD_FLUSH_EN
      m_fl = rd_flush;
`else
      m_fl = 1'b0;
`endif
      m_valid = (n_arr > n_pop);
      m_pop   = m_valid && rd_ready && !m_fl;
      m_iss   = !m_fl && (w > n_iss) && (((n_iss - n_pop) < 2) || m_pop);
      chk("mem_rd_en", 32'(mem_rd_en), 32'(m_iss));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      if (m_valid) chk("rd_data", 32'(rd_data), 32'(wq[n_pop]));
      chk("rd_ptr", 32'(rd_ptr), 32'(ptr_of(n_iss)));
      chk("rd_count", 32'(rd_count), 32'(w - n_pop));
      chk("rd_empty", 32'(rd_empty), 32'(w == n_pop));
      chk("rd_almost_empty", 32'(rd_almost_empty), 32'((w - n_pop) <= 2));
      if (rd_valid && rd_ready) pops++;
      if (rd_almost_empty && !ae_prev) ae_rise = int'(rd_count);
      ae_prev = rd_almost_empty;
      if (rd_ptr == 4'b1000) saw_ph1 = 1;
      if (m_fl) begin
        n_iss = w; n_arr = w; n_pop = w; prev_iss = 0;
      end else begin
        n_arr    += int'(prev_iss);
        prev_iss  = m_iss;
        n_iss    += int'(m_iss);
        n_pop    += int'(m_pop);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    bit stale;
    n_vec = 0; n_err = 0; w = 0; pops = 0; ae_rise = 99; saw_ph1 = 0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_rd_empty", 32'(rd_empty), 1);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    do_reset();

    // Single word: issue in the cycle wr_ptr moves, valid two cycles later.
    put(8'hA5);
    #1;
    chk("t1_issue_same_cycle", 32'(mem_rd_en), 1);
    cyc();
    chk("t1_not_yet_valid", 32'(rd_valid), 0);
    cyc();
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_data", 32'(rd_data), 32'h A5);
    chk("t1_count", 32'(rd_count), 1);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("t1_count_after_pop", 32'(rd_count), 0);
    chk("t1_empty_after_pop", 32'(rd_empty), 1);

    // Stream of 12 words with rd_ready held high: one pop per cycle after fill.
    do_reset();
    rd_ready = 1'b1; pops = 0; saw_ph1 = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 12) put(8'h10 + 8'(k));
      cyc();
    end
    chk("st_pops_full_rate", 32'(pops), 12);
    chk("st_count_drained", 32'(rd_count), 0);
    chk("st_saw_phase1_addr0", 32'(saw_ph1), 1);
    chk("st_final_rd_ptr", 32'(rd_ptr), 32'h2);
    rd_ready = 1'b0;

    // Backpressure with 5 stored words, then alternating ready until drained.
    do_reset();
    pops = 0; ae_rise = 99;
    for (int k = 0; k < 5; k++) begin
      put(8'h30 + 8'(k));
      cyc();
    end
    repeat (4) cyc();
    chk("bp_count", 32'(rd_count), 5);
    chk("bp_issue_stopped", 32'(mem_rd_en), 0);
    chk("bp_almost_empty", 32'(rd_almost_empty), 0);
    chk("bp_rd_ptr_two_fetched", 32'(rd_ptr), 2);
    chk("bp_head", 32'(rd_data), 32'h30);
    for (int k = 0; k < 16; k++) begin
      rd_ready = (k % 2 == 0);
      cyc();
    end
    rd_ready = 1'b0;
    chk("bp_pops", 32'(pops), 5);
    chk("bp_ae_rise_count", 32'(ae_rise), 2);
    chk("bp_empty", 32'(rd_empty), 1);
    chk("bp_rd_ptr_wrapped", 32'(rd_ptr), 32'h8);

    // Asynchronous reset with the buffer full.
    for (int k = 0; k < 3; k++) begin
      put(8'h50 + 8'(k));
      cyc();
    end
    repeat (3) cyc();
    chk("mr_pre_valid", 32'(rd_valid), 1);
    reset_n = 1'b0;
    wr_ptr  = '0;
    w       = 0;
    wq.delete();
    #1;
    chk("mr_rd_valid", 32'(rd_valid), 0);
    chk("mr_rd_ptr", 32'(rd_ptr), 0);
    chk("mr_rd_count", 32'(rd_count), 0);
    chk("mr_mem_rd_en", 32'(mem_rd_en), 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("mr_no_stale_valid", 32'(rd_valid), 0);

`ifdef FIFO_RD_FLUSH_EN
    // Flush with a word held, one in flight, and a pop requested.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      put(8'h60 + 8'(k));
      cyc();
    end
    repeat (3) cyc();
    rd_ready = 1'b1;
    cyc();
    rd_flush = 1'b1;
    cyc();
    rd_flush = 1'b0;
    rd_ready = 1'b0;
    chk("fl_rd_valid", 32'(rd_valid), 0);
    chk("fl_rd_ptr_eq_wr", 32'(rd_ptr), 32'h8);
    chk("fl_rd_empty", 32'(rd_empty), 1);
    stale = 0;
    repeat (4) begin
      cyc();
      if (rd_valid) stale = 1;
    end
    chk("fl_no_stale_word", 32'(stale), 0);
    put(8'h77);
    repeat (3) cyc();
    chk("fl_new_valid", 32'(rd_valid), 1);
    chk("fl_new_data", 32'(rd_data), 32'h77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
